// File: rtl/proj_param_pkg.sv
// Project-wide sizing parameters shared by chip-level blocks.
//   PROJ_GPIO : number of GPIO pads on the chip
package proj_param_pkg;

  localparam int unsigned PROJ_GPIO = 8;

endpackage

// File: rtl/verilab_chip_gpio_pkg.sv
// Shared types and sizing helpers for the GPIO edge-capture block.
//   gpio_cap_state_e : clear-handshake FSM states
//   cnt_width()      : bits needed to hold a count of 0..max_count
//   init_cycles()    : cycles spent in INIT before the debounce logic takes over
package verilab_chip_gpio_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACK
  } gpio_cap_state_e;

  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int unsigned INIT_CYCLES = SYNC_STAGES_DEFAULT + DEBOUNCE_CYCLES_DEFAULT;

  function automatic int unsigned cnt_width(int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int unsigned init_cycles(int unsigned sync_stages,
                                              int unsigned debounce_cycles);
    return sync_stages + debounce_cycles;
  endfunction

endpackage

// File: rtl/verilab_chip_gpio_debounce.sv
// One GPIO bit: synchroniser chain, debounce counter and commit pulses.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   gpio_i   : raw pad input, asynchronous to clk_i
//   bypass_i : while high, filt_o follows the synchronised input with no debounce
//   filt_o   : debounced level
//   rise_o   : one-cycle pulse, high in the cycle filt_o commits 0->1
//   fall_o   : one-cycle pulse, high in the cycle filt_o commits 1->0
module verilab_chip_gpio_debounce
  import verilab_chip_gpio_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic gpio_i,
  input  logic bypass_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sync;
  logic                  filt_q, filt_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  assign sync = sync_q[SyncStages-1];

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    rise_o = 1'b0;
    fall_o = 1'b0;
    if (bypass_i) begin
      filt_d = sync;
      cnt_d  = '0;
    end else if (sync == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // Input has differed for DebounceCycles consecutive cycles: commit.
      filt_d = sync;
      cnt_d  = '0;
      rise_o = sync;
      fall_o = ~sync;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], gpio_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/verilab_chip_gpio_edge_capture.sv
// GPIO input stage: per-pin synchronise + debounce, sticky rise/fall capture,
// level interrupt, and a valid/ready port for firmware to clear captured bits.
//   clk, rst          : clock, asynchronous active-high reset
//   gpio_in           : raw pad inputs
//   rise_en, fall_en  : per-bit capture enables, sampled on the commit cycle
//   clr_valid/ready   : clear handshake; clr_mask sampled on acceptance
//   gpio_filt         : debounced pin levels
//   status            : sticky edge-capture bits
//   irq               : OR of status
module verilab_chip_gpio_edge_capture
  import verilab_chip_gpio_pkg::*;
#(
  parameter int unsigned GPIO            = proj_param_pkg::PROJ_GPIO,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [GPIO-1:0] gpio_in,
  input  logic [GPIO-1:0] rise_en,
  input  logic [GPIO-1:0] fall_en,
  input  logic            clr_valid,
  input  logic [GPIO-1:0] clr_mask,
  output logic            clr_ready,
  output logic [GPIO-1:0] gpio_filt,
  output logic [GPIO-1:0] status,
  output logic            irq
);

  localparam int unsigned InitCycles = init_cycles(SYNC_STAGES, DEBOUNCE_CYCLES);
  localparam int unsigned InitW      = cnt_width(InitCycles);
  localparam logic [InitW-1:0] InitMax = InitW'(InitCycles - 1);

  gpio_cap_state_e   state_q;
  logic [InitW-1:0]  init_cnt_q;
  logic              clr_ready_q;
  logic [GPIO-1:0]   rise, fall, set;
  logic [GPIO-1:0]   status_q, status_d;
  logic              bypass;
  logic              clr_accept;

  // During INIT the filters track their inputs directly so pins already high
  // at reset release settle without being reported as edges.
  assign bypass = (state_q == INIT);

  for (genvar i = 0; i < GPIO; i++) begin : g_bit
    verilab_chip_gpio_debounce #(
      .SyncStages    (SYNC_STAGES),
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk),
      .rst_i   (rst),
      .gpio_i  (gpio_in[i]),
      .bypass_i(bypass),
      .filt_o  (gpio_filt[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  assign clr_accept = clr_valid && clr_ready_q;
  assign set        = (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      clr_ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_cnt_q == InitMax) begin
            state_q     <= IDLE;
            clr_ready_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + InitW'(1);
          end
        end
        IDLE: begin
          if (clr_valid) begin
            state_q     <= ACK;
            clr_ready_q <= 1'b0;
          end
        end
        ACK: begin
          state_q     <= IDLE;
          clr_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= INIT;
          clr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Clear is applied before the set so a same-cycle commit keeps its bit.
  always_comb begin
    status_d = status_q;
    if (!bypass) begin
      if (clr_accept) begin
        status_d = status_d & ~clr_mask;
      end
      status_d = status_d | set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status    = status_q;
  assign irq       = |status_q;
  assign clr_ready = clr_ready_q;

endmodule

// File: tb/tb_verilab_chip_gpio_edge_capture.sv
// Bench for verilab_chip_gpio_edge_capture (GPIO=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A reference model updates on each rising edge from the applied inputs and queues
// the expected outputs; a monitor on the falling edge pops and compares.
module tb_verilab_chip_gpio_edge_capture;
  import verilab_chip_gpio_pkg::*;

  localparam int Sync = 2;
  localparam int Deb  = 4;

  logic       clk;
  logic       rst       = 1'b1;
  logic [7:0] gpio_in   = 8'h00;
  logic [7:0] rise_en   = 8'h00;
  logic [7:0] fall_en   = 8'h00;
  logic       clr_valid = 1'b0;
  logic [7:0] clr_mask  = 8'h00;
  logic       clr_ready;
  logic [7:0] gpio_filt;
  logic [7:0] status;
  logic       irq;

  int checks = 0;
  int errors = 0;

  verilab_chip_gpio_edge_capture #(
    .GPIO           (8),
    .SYNC_STAGES    (Sync),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gpio_in  (gpio_in),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .clr_valid(clr_valid),
    .clr_mask (clr_mask),
    .clr_ready(clr_ready),
    .gpio_filt(gpio_filt),
    .status   (status),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] filt;
    logic [7:0] status;
    logic       irq;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- reference model ----------------
  // Pins are seen SYNC edges after they are applied; a new level is adopted once
  // the last DEB seen samples all disagree with the current level.
  int         m_edges;
  logic [7:0] m_in_hist[$];
  logic [7:0] m_seen_hist[$];
  logic [7:0] m_filt, m_status, m_seen, m_flip, m_set;
  bit         m_ready, m_ack;

  always @(posedge clk) begin
    if (rst) begin
      m_edges = 0;
      m_in_hist.delete();
      m_seen_hist.delete();
      m_filt   = 8'h00;
      m_status = 8'h00;
      m_ready  = 1'b0;
      m_ack    = 1'b0;
    end else begin
      m_edges++;
      m_seen = (m_in_hist.size() >= Sync) ? m_in_hist[m_in_hist.size() - Sync] : 8'h00;
      m_in_hist.push_back(gpio_in);
      m_seen_hist.push_back(m_seen);
      if (m_in_hist.size() > 16) m_in_hist.delete(0);
      if (m_seen_hist.size() > 16) m_seen_hist.delete(0);
      if (m_edges <= int'(INIT_CYCLES)) begin
        m_filt = m_seen;
        if (m_edges == int'(INIT_CYCLES)) m_ready = 1'b1;
      end else begin
        m_flip = 8'h00;
        for (int b = 0; b < 8; b++) begin
          bit all_differ;
          all_differ = 1'b1;
          for (int j = 0; j < Deb; j++) begin
            if (m_seen_hist[m_seen_hist.size() - 1 - j][b] == m_filt[b]) all_differ = 1'b0;
          end
          m_flip[b] = all_differ;
        end
        m_set  = (m_flip & ~m_filt & rise_en) | (m_flip & m_filt & fall_en);
        m_filt = m_filt ^ m_flip;
        if (m_ack) begin
          m_ack   = 1'b0;
          m_ready = 1'b1;
        end else if (m_ready && clr_valid) begin
          m_status = m_status & ~clr_mask;
          m_ready  = 1'b0;
          m_ack    = 1'b1;
        end
        m_status = m_status | m_set;
      end
    end
    exp_q.push_back('{filt: m_filt, status: m_status, irq: |m_status, ready: m_ready});
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      check("reset_filt", gpio_filt, 8'h00);
      check("reset_status", status, 8'h00);
      check("reset_irq", {7'd0, irq}, 8'h00);
      check("reset_ready", {7'd0, clr_ready}, 8'h00);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t: actual=0 entries required>=1", $time);
    end else begin
      e = exp_q.pop_front();
      check("gpio_filt", gpio_filt, e.filt);
      check("status", status, e.status);
      check("irq", {7'd0, irq}, {7'd0, e.irq});
      check("clr_ready", {7'd0, clr_ready}, {7'd0, e.ready});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_all();
    clr_mask  = 8'hFF;
    clr_valid = 1'b1;
    tick(1);
    clr_valid = 1'b0;
    tick(2);
  endtask

  initial begin
    // Reset with pins low, then settle into IDLE.
    tick(3);
    rst = 1'b0;
    tick(8);

    // Clean rise on bit 0.
    rise_en = 8'hFF;
    gpio_in = 8'h01;
    tick(8);

    // 3-cycle glitch (filtered) then 4-cycle pulse (commits) on bit 3.
    gpio_in[3] = 1'b1;
    tick(3);
    gpio_in[3] = 1'b0;
    tick(8);
    gpio_in[3] = 1'b1;
    tick(4);
    gpio_in[3] = 1'b0;
    tick(10);
    clear_all();

    // Build status=05, then race a clear against a fall commit on bit 2.
    gpio_in = 8'h00;
    tick(8);
    gpio_in = 8'h05;
    tick(8);
    rise_en = 8'h00;
    fall_en = 8'h04;
    gpio_in = 8'h01;
    tick(5);
    clr_mask  = 8'h05;
    clr_valid = 1'b1;
    tick(1);
    clr_valid = 1'b0;
    tick(3);

    // Held clr_valid: accepted once per two cycles.
    clr_mask  = 8'h04;
    clr_valid = 1'b1;
    tick(4);
    clr_valid = 1'b0;
    tick(2);

    // Only the enabled fall on bit 4 is captured.
    clear_all();
    rise_en = 8'h00;
    fall_en = 8'h10;
    gpio_in[4] = 1'b1;
    tick(8);
    gpio_in[4] = 1'b0;
    tick(8);

    // Reset mid-debounce with a pending clear, clear held across release.
    gpio_in[1] = 1'b1;
    tick(4);
    clr_mask  = 8'hFF;
    clr_valid = 1'b1;
    rst       = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    clr_valid = 1'b0;
    tick(8);

    // Pins high through reset release produce no edges.
    rst     = 1'b1;
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    gpio_in = 8'hA5;
    tick(3);
    rst = 1'b0;
    tick(10);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = int'($urandom_range(0, 7));
        gpio_in[b] = ~gpio_in[b];
      end
      if ($urandom_range(0, 49) == 0) begin
        rise_en = 8'($urandom);
        fall_en = 8'($urandom);
      end
      clr_valid = ($urandom_range(0, 3) == 0);
      clr_mask  = 8'($urandom);
      if (i == 700) rst = 1'b1;
      if (i == 703) rst = 1'b0;
      tick(1);
    end
    clr_valid = 1'b0;
    tick(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
